selector_corriente: RTL
=======================

Name: selector_corriente

Overview:
- Producer end of the 5-bit current-level code `contador_I` that feeds the current decoder (level × 32 → PWM max count).
- Converts two raw board pushbuttons (up/down) into a saturating 0..31 level.
- Per-button path: two-flop synchronizer → debouncer → press FSM.
- Also emits a one-cycle change strobe and limit flags for display/PWM reload logic.

Parameters:
- DEBOUNCE_CYCLES, 500000, cycles a synchronized input must stay stable before its debounced state updates (10 ms at 50 MHz).
- REPEAT_DELAY, 25000000, cycles a button must be held after the first step before auto-repeat starts (only used with SELECTOR_AUTOREPEAT_EN).
- REPEAT_RATE, 5000000, cycles between auto-repeat steps (only used with SELECTOR_AUTOREPEAT_EN).
- NIVEL_INICIAL, 0, level loaded on reset, range 0..31.

Ports:
- clk  input  1  system clock; only clock.
- reset  input  1  synchronous, active-high reset.
- btn_up  input  1  raw pushbutton, asynchronous, active-high.
- btn_down  input  1  raw pushbutton, asynchronous, active-high.
- contador_I  output  5  registered current level, 0..31.
- cambio  output  1  one-cycle pulse in the cycle `contador_I` takes its new value.
- en_max  output  1  high while `contador_I` = 31.
- en_min  output  1  high while `contador_I` = 0.

Behaviour:
- Reset is sampled on the `clk` rising edge. On reset:
  - `contador_I` = NIVEL_INICIAL; `cambio` = 0.
  - `en_max` / `en_min` take values consistent with NIVEL_INICIAL.
  - Synchronizers, debounced states and debounce counters = 0.
  - FSM → IDLE.
- Reset asserted mid-hold or mid-debounce aborts everything. A button still held when reset releases must first debounce to 1 from the cleared state, and then produces exactly one step.
- Synchronizer: 2 flops per button. Their outputs are not used directly.
- Debouncer (per button):
  - Counter clears whenever the synchronized input equals the debounced state.
  - Otherwise the counter increments.
  - When it reaches DEBOUNCE_CYCLES-1, the debounced state takes the synchronized value and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES never change the debounced state.
- Request decode, from debounced states:
  - up = deb_up & ~deb_down
  - down = deb_down & ~deb_up
  - Both pressed = no request.
- FSM states: IDLE, PULSADO, REPETIR.
  - IDLE: on a rising edge of a request, issue one step and go to PULSADO.
  - PULSADO: the request dropping, or both buttons becoming pressed, returns to IDLE. (Auto-repeat behaviour: see Optional Feature.)
  - REPETIR: the request dropping, or both buttons becoming pressed, returns to IDLE.
- Step:
  - Up step: `contador_I`+1, saturating at 31.
  - Down step: `contador_I`-1, saturating at 0.
  - Latency: debounced edge → `contador_I` update is 1 cycle.
  - `cambio` = 1 in the same cycle as the update, only if the value actually changed. Saturated steps produce no `cambio`.
- `en_max` / `en_min` are combinational compares of the registered `contador_I`.
- No wrap-around under any condition.

Optional Feature:
- Macro: SELECTOR_AUTOREPEAT_EN.
- Defined:
  - In PULSADO a hold counter runs; after REPEAT_DELAY cycles with the request held, go to REPETIR and issue a step.
  - In REPETIR, issue a further step every REPEAT_RATE cycles while the request is held.
  - Saturation and `cambio` rules apply to every repeated step.
- Undefined:
  - REPETIR and its counters are not built.
  - PULSADO waits only for release; exactly one step per debounced press.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=5, NIVEL_INICIAL=0):
- Reset held 3 cycles → `contador_I`=0, `en_min`=1, `en_max`=0, `cambio`=0; release reset, no buttons → values unchanged for 100 cycles.
- `btn_up` pulsed high for 2 cycles (glitch) → `contador_I` stays 0, no `cambio`. `btn_up` held 10 cycles then released → `contador_I`=1, exactly one `cambio` pulse, first visible 2+4+1 cycles after assertion.
- 31 clean up-presses → `contador_I`=31, `en_max`=1. A 32nd press → stays 31, no `cambio`.
- From 5, hold both buttons 50 cycles → `contador_I` stays 5. Release `btn_down` only while `btn_up` stays held → no step (no rising edge of up request from IDLE until up is re-pressed).
- From 3, press up and assert reset during debounce → `contador_I`=0 after reset. Keep `btn_up` held through release → exactly one step to 1.
- With SELECTOR_AUTOREPEAT_EN: from 0, hold `btn_down` 200 cycles → stays 0, no `cambio`. Hold `btn_up` for 1+20+3×5 cycles past debounce → `contador_I`=5 (1 initial + 4 repeats). Without the macro, same stimulus → `contador_I`=1.

Source files
------------

// File: rtl/selector_corriente.sv
// Up/down pushbutton front end producing the saturating 5-bit current level contador_I.
// Optional auto-repeat while a button is held is built only with SELECTOR_AUTOREPEAT_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | no press in progress; waiting for a fresh up or down press
// PULSADO | first step issued; waiting for release (or the repeat delay)
// REPETIR | auto-repeating every REPEAT_RATE cycles while held (macro only)
module selector_corriente #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_RATE     = 5000000,
    parameter int unsigned NIVEL_INICIAL   = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [4:0] contador_I,
    output logic       cambio,
    output logic       en_max,
    output logic       en_min
);

    localparam int DEB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [4:0]       NIVEL_RST = 5'(NIVEL_INICIAL);
    localparam logic [4:0]       NIVEL_MAX = 5'd31;

    if (DEBOUNCE_CYCLES < 1 || NIVEL_INICIAL > 31 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
        $error("selector_corriente: invalid parameter set");
    end

`ifdef SELECTOR_AUTOREPEAT_EN
    typedef enum logic [1:0] {IDLE, PULSADO, REPETIR} state_t;
    localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int HOLD_W = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
    localparam logic [HOLD_W-1:0] DELAY_LAST = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] RATE_LAST  = HOLD_W'(REPEAT_RATE - 1);
    logic [HOLD_W-1:0] hold_cnt;
`else
    typedef enum logic [1:0] {IDLE, PULSADO} state_t;
`endif

    // Index 0 = up button, index 1 = down button.
    logic [1:0]       sync_a;
    logic [1:0]       sync_b;
    logic [1:0]       deb;
    logic [1:0]       deb_prev;
    logic [DEB_W-1:0] deb_cnt [2];

    state_t state;
    logic   dir_up;
    logic   req_up, req_down, up_edge, down_edge, held;
    logic   step_en, step_is_up;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a   <= '0;
            sync_b   <= '0;
            deb      <= '0;
            deb_prev <= '0;
            for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
        end else begin
            sync_a   <= {btn_down, btn_up};
            sync_b   <= sync_a;
            deb_prev <= deb;
            for (int i = 0; i < 2; i++) begin
                if (sync_b[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb[i]     <= sync_b[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    // A new press must be a debounced rising edge of that button itself, so
    // releasing the other button of a held pair never starts a step.
    assign req_up    = deb[0] & ~deb[1];
    assign req_down  = deb[1] & ~deb[0];
    assign up_edge   = req_up & ~deb_prev[0];
    assign down_edge = req_down & ~deb_prev[1];
    assign held      = dir_up ? req_up : req_down;

    always_comb begin
        step_en    = 1'b0;
        step_is_up = dir_up;
        if (state == IDLE) begin
            step_en    = up_edge | down_edge;
            step_is_up = up_edge;
        end
`ifdef SELECTOR_AUTOREPEAT_EN
        else if (held && hold_cnt == '0) begin
            step_en = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            dir_up     <= 1'b0;
            contador_I <= NIVEL_RST;
            cambio     <= 1'b0;
`ifdef SELECTOR_AUTOREPEAT_EN
            hold_cnt   <= '0;
`endif
        end else begin
            cambio <= 1'b0;
            if (step_en) begin
                if (step_is_up && contador_I != NIVEL_MAX) begin
                    contador_I <= contador_I + 5'd1;
                    cambio     <= 1'b1;
                end else if (!step_is_up && contador_I != 5'd0) begin
                    contador_I <= contador_I - 5'd1;
                    cambio     <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (up_edge || down_edge) begin
                        state  <= PULSADO;
                        dir_up <= up_edge;
`ifdef SELECTOR_AUTOREPEAT_EN
                        hold_cnt <= DELAY_LAST;
`endif
                    end
                end
                PULSADO: begin
                    if (!held) begin
                        state <= IDLE;
                    end
`ifdef SELECTOR_AUTOREPEAT_EN
                    else if (hold_cnt == '0) begin
                        state    <= REPETIR;
                        hold_cnt <= RATE_LAST;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
`endif
                end
`ifdef SELECTOR_AUTOREPEAT_EN
                REPETIR: begin
                    if (!held) begin
                        state <= IDLE;
                    end else if (hold_cnt == '0) begin
                        hold_cnt <= RATE_LAST;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    assign en_max = (contador_I == NIVEL_MAX);
    assign en_min = (contador_I == 5'd0);

endmodule
